// File: rtl/sauria_cfg_pkg.sv
// ---------------------------------------------------------------------------
// sauria_cfg_pkg
//   Shared configuration for the feeder-lane slice.
//   - clog2_safe       : $clog2 that never returns a zero width
//   - shim_stage_t     : one output-shim stage {valid, data}
//   - FEED_ELEM_W      : element width carried by a shim stage; a lane's
//                        I_W parameter must match it
//   - FEED_UNDERFLOW_CNT_W : width of the optional underflow counter
// ---------------------------------------------------------------------------
package sauria_cfg_pkg;

  localparam int FEED_UNDERFLOW_CNT_W = 16;
  localparam int FEED_ELEM_W          = 16;

  typedef struct packed {
    logic                   valid;
    logic [FEED_ELEM_W-1:0] data;
  } shim_stage_t;

  // Width needed to index 'value' distinct positions, at least 1 bit.
  function automatic int clog2_safe(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/fifo_packed_ff.sv
// ---------------------------------------------------------------------------
// fifo_packed_ff
//   Element-granular flop FIFO: writes 1..M elements per cycle from a packed
//   word, reads one element per cycle, tracks occupancy.
//   The caller only asserts wr_en for legal, non-overflowing pushes and only
//   asserts rd_en when the FIFO is non-empty.
// Ports:
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   clear         : synchronous clear of pointers and occupancy (wins)
//   wr_en         : write wr_cnt elements of wr_data (element 0 in LSBs)
//   wr_cnt        : number of elements to write
//   wr_data       : packed M-element write word
//   rd_en         : advance the read pointer past the head element
//   rd_data       : head element (combinational)
//   occupancy     : current element count
// ---------------------------------------------------------------------------
module fifo_packed_ff
  import sauria_cfg_pkg::*;
#(
  parameter int I_W            = 16,
  parameter int M              = 3,
  parameter int FIFO_POSITIONS = 16,
  parameter int CNT_W          = $clog2(FIFO_POSITIONS + 1),
  parameter int PC_W           = clog2_safe(M + 1)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               clear,
  input  logic               wr_en,
  input  logic [PC_W-1:0]    wr_cnt,
  input  logic [M*I_W-1:0]   wr_data,
  input  logic               rd_en,
  output logic [I_W-1:0]     rd_data,
  output logic [CNT_W-1:0]   occupancy
);

  localparam int PTR_W = clog2_safe(FIFO_POSITIONS);

  logic [I_W-1:0]   mem [FIFO_POSITIONS];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] occ;

  // Pointers wrap naturally because FIFO_POSITIONS is a power of two.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_W'(wr_cnt);
      if (rd_en) rptr <= rptr + PTR_W'(1);
      occ <= occ + (wr_en ? CNT_W'(wr_cnt) : '0) - CNT_W'(rd_en);
    end
  end

  // Storage carries no reset; each element lands at its own wrapped slot so
  // a partial word straddling the end of the array is split correctly.
  always_ff @(posedge i_clk) begin
    if (wr_en && !clear) begin
      for (int i = 0; i < M; i++) begin
        if (i < int'(wr_cnt)) mem[wptr + PTR_W'(i)] <= wr_data[i*I_W +: I_W];
      end
    end
  end

  assign rd_data   = mem[rptr];
  assign occupancy = occ;

endmodule

// File: rtl/feed_lane_packed.sv
// ---------------------------------------------------------------------------
// feed_lane_packed
//   Feeder lane buffer between the feed data manager and one systolic-array
//   row/column input. Accepts packed words of 1..M elements and streams one
//   element per pipeline step through a SHIM_LAT-deep output shim.
//   I_W must equal sauria_cfg_pkg::FEED_ELEM_W (width of a shim stage).
// Optional feature:
//   `define FEED_LANE_UNDERFLOW_CNT_EN adds o_underflow_cnt, a saturating
//   count of pops taken while the FIFO was empty.
// Ports:
//   i_clk, i_rstn   : clock, asynchronous active-low reset
//   i_din           : packed push word, element 0 in LSBs (pushed first)
//   i_push          : push request
//   i_push_cnt      : valid elements in i_din (1..M)
//   i_clearfifo     : synchronous clear of FIFO, pop register and shim
//   i_pipeline_en   : systolic-array pipeline enable
//   i_pop_en        : pop request (registered before use)
//   o_fifo_full     : free space < M
//   o_fifo_afull    : registered occupancy >= AF_THRESH
//   o_fifo_empty    : occupancy == 0
//   o_occupancy     : current element count
//   o_underflow_cnt : (optional) empty-pop counter
//   o_valid         : o_data carries a real element
//   o_data          : element stream, 0 when not valid
// ---------------------------------------------------------------------------
module feed_lane_packed
  import sauria_cfg_pkg::*;
#(
  parameter int I_W            = 16,
  parameter int M              = 3,
  parameter int FIFO_POSITIONS = 16,
  parameter int SHIM_LAT       = 2,
  parameter int AF_THRESH      = 12,
  parameter int CNT_W          = $clog2(FIFO_POSITIONS + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_rstn,
  input  logic [M*I_W-1:0]                i_din,
  input  logic                            i_push,
  input  logic [clog2_safe(M+1)-1:0]      i_push_cnt,
  input  logic                            i_clearfifo,
  input  logic                            i_pipeline_en,
  input  logic                            i_pop_en,
  output logic                            o_fifo_full,
  output logic                            o_fifo_afull,
  output logic                            o_fifo_empty,
  output logic [CNT_W-1:0]                o_occupancy,
`ifdef FEED_LANE_UNDERFLOW_CNT_EN
  output logic [FEED_UNDERFLOW_CNT_W-1:0] o_underflow_cnt,
`endif
  output logic                            o_valid,
  output logic [I_W-1:0]                  o_data
);

  localparam int PC_W = clog2_safe(M + 1);

  logic             pop_en_q;
  logic             fifo_pop;
  logic             fifo_full;
  logic             push_legal;
  logic             push_ok;
  logic             rd_en;
  logic             afull_q;
  logic [CNT_W-1:0] occ;
  logic [I_W-1:0]   head;
  shim_stage_t      shim_p [SHIM_LAT];

  assign fifo_full  = (CNT_W'(FIFO_POSITIONS) - occ) < CNT_W'(M);
  assign push_legal = (i_push_cnt != '0) && (i_push_cnt <= PC_W'(M));
  assign push_ok    = i_push && !fifo_full && push_legal && !i_clearfifo;
  assign fifo_pop   = pop_en_q && i_pipeline_en;
  // An empty-FIFO pop only injects a bubble; a push in the same cycle is
  // not visible to it.
  assign rd_en      = fifo_pop && (occ != '0) && !i_clearfifo;

  fifo_packed_ff #(
    .I_W            (I_W),
    .M              (M),
    .FIFO_POSITIONS (FIFO_POSITIONS),
    .CNT_W          (CNT_W),
    .PC_W           (PC_W)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .clear     (i_clearfifo),
    .wr_en     (push_ok),
    .wr_cnt    (i_push_cnt),
    .wr_data   (i_din),
    .rd_en     (rd_en),
    .rd_data   (head),
    .occupancy (occ)
  );

  // ---- pop request register and almost-full flag --------------------------
  // afull lags occupancy by one cycle to cover downstream read-enable latency.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pop_en_q <= 1'b0;
      afull_q  <= 1'b0;
    end else if (i_clearfifo) begin
      pop_en_q <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      if (i_pipeline_en) pop_en_q <= i_pop_en;
      afull_q <= (occ >= CNT_W'(AF_THRESH));
    end
  end

  // ---- output shim: shifts only on a pop, holds while the array stalls ----
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < SHIM_LAT; k++) shim_p[k] <= '0;
    end else if (i_clearfifo) begin
      for (int k = 0; k < SHIM_LAT; k++) shim_p[k] <= '0;
    end else if (fifo_pop) begin
      shim_p[0].valid <= rd_en;
      shim_p[0].data  <= rd_en ? head : '0;
      for (int k = 1; k < SHIM_LAT; k++) shim_p[k] <= shim_p[k-1];
    end
  end

  // ---- outputs -------------------------------------------------------------
  assign o_valid      = fifo_pop && shim_p[SHIM_LAT-1].valid;
  assign o_data       = o_valid ? shim_p[SHIM_LAT-1].data : '0;
  assign o_fifo_full  = fifo_full;
  assign o_fifo_afull = afull_q;
  assign o_fifo_empty = (occ == '0);
  assign o_occupancy  = occ;

`ifdef FEED_LANE_UNDERFLOW_CNT_EN
  logic [FEED_UNDERFLOW_CNT_W-1:0] uf_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      uf_cnt <= '0;
    end else if (i_clearfifo) begin
      uf_cnt <= '0;
    end else if (fifo_pop && (occ == '0) && (uf_cnt != '1)) begin
      uf_cnt <= uf_cnt + FEED_UNDERFLOW_CNT_W'(1);
    end
  end

  assign o_underflow_cnt = uf_cnt;
`endif

`ifndef SYNTHESIS
  // Push counts outside 1..M are dropped by the datapath; flag them in sim.
  a_push_cnt_legal: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_push |-> push_legal);
`endif

endmodule

// File: tb/tb_feed_lane_packed.sv
module tb_feed_lane_packed;
  localparam int I_W            = 16;
  localparam int M              = 3;
  localparam int FIFO_POSITIONS = 16;
  localparam int SHIM_LAT       = 2;
  localparam int AF_THRESH      = 12;
  localparam int CNT_W          = $clog2(FIFO_POSITIONS + 1);
  localparam int PC_W           = $clog2(M + 1);

  logic               i_clk = 1'b0;
  logic               i_rstn = 1'b0;
  logic [M*I_W-1:0]   i_din = '0;
  logic               i_push = 1'b0;
  logic [PC_W-1:0]    i_push_cnt = '0;
  logic               i_clearfifo = 1'b0;
  logic               i_pipeline_en = 1'b1;
  logic               i_pop_en = 1'b0;
  logic               o_fifo_full;
  logic               o_fifo_afull;
  logic               o_fifo_empty;
  logic [CNT_W-1:0]   o_occupancy;
  logic               o_valid;
  logic [I_W-1:0]     o_data;
`ifdef FEED_LANE_UNDERFLOW_CNT_EN
  logic [15:0]        o_underflow_cnt;
`endif

  always #5 i_clk = ~i_clk;

  feed_lane_packed #(
    .I_W(I_W), .M(M), .FIFO_POSITIONS(FIFO_POSITIONS),
    .SHIM_LAT(SHIM_LAT), .AF_THRESH(AF_THRESH), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_din(i_din), .i_push(i_push),
    .i_push_cnt(i_push_cnt), .i_clearfifo(i_clearfifo),
    .i_pipeline_en(i_pipeline_en), .i_pop_en(i_pop_en),
    .o_fifo_full(o_fifo_full), .o_fifo_afull(o_fifo_afull),
    .o_fifo_empty(o_fifo_empty), .o_occupancy(o_occupancy),
`ifdef FEED_LANE_UNDERFLOW_CNT_EN
    .o_underflow_cnt(o_underflow_cnt),
`endif
    .o_valid(o_valid), .o_data(o_data)
  );

  // Reference model: element queue, registered pop request, shim as a
  // fixed-length queue (front = newest), afull flag and underflow count.
  typedef struct { bit v; bit [I_W-1:0] d; } ent_t;
  bit [I_W-1:0] mq[$];
  ent_t         mshim[$];
  bit           mpop;
  bit           mafull;
  int           muf;
  int           cyc;
  int           outlog[$];
  int           outcyc[$];
  int           checks;
  int           errors;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int logged(int idx);
    if (idx < outlog.size()) return outlog[idx];
    return -1;
  endfunction

  task automatic model_reset();
    ent_t b;
    b.v = 0; b.d = '0;
    mq.delete();
    mshim.delete();
    for (int k = 0; k < SHIM_LAT; k++) mshim.push_back(b);
    mpop = 0; mafull = 0; muf = 0;
  endtask

  task automatic model_tick();
    int   occ;
    bit   full;
    ent_t e;
    if (!i_rstn) begin
      model_reset();
    end else if (i_clearfifo) begin
      model_reset();
    end else begin
      occ  = mq.size();
      full = (FIFO_POSITIONS - occ) < M;
      mafull = (occ >= AF_THRESH);
      if (mpop && i_pipeline_en) begin
        if (occ > 0) begin
          e.v = 1; e.d = mq.pop_front();
        end else begin
          e.v = 0; e.d = '0;
          if (muf < 65535) muf++;
        end
        mshim.push_front(e);
        void'(mshim.pop_back());
      end
      if (i_push && !full && i_push_cnt >= 1 && i_push_cnt <= M)
        for (int k = 0; k < int'(i_push_cnt); k++) mq.push_back(i_din[k*I_W +: I_W]);
      if (i_pipeline_en) mpop = i_pop_en;
    end
  endtask

  task automatic compare();
    int e_occ, e_d, e_uf;
    bit e_full, e_empty, e_af, e_v;
    if (!i_rstn) begin
      e_occ = 0; e_full = 0; e_empty = 1; e_af = 0; e_v = 0; e_d = 0; e_uf = 0;
    end else begin
      e_occ   = mq.size();
      e_full  = (FIFO_POSITIONS - e_occ) < M;
      e_empty = (e_occ == 0);
      e_af    = mafull;
      e_v     = mpop && i_pipeline_en && mshim[SHIM_LAT-1].v;
      e_d     = e_v ? int'(mshim[SHIM_LAT-1].d) : 0;
      e_uf    = muf;
    end
    chk("occupancy", o_occupancy, e_occ);
    chk("full", o_fifo_full, e_full);
    chk("empty", o_fifo_empty, e_empty);
    chk("afull", o_fifo_afull, e_af);
    chk("valid", o_valid, e_v);
    chk("data", o_data, e_d);
`ifdef FEED_LANE_UNDERFLOW_CNT_EN
    chk("underflow_cnt", o_underflow_cnt, e_uf);
`endif
    if (i_rstn && o_valid) begin
      outlog.push_back(int'(o_data));
      outcyc.push_back(cyc);
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising
  // edge, then return 1 time unit later so the caller can drive new inputs.
  task automatic step();
    @(negedge i_clk);
    compare();
    @(posedge i_clk);
    model_tick();
    cyc++;
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_word(input int cnt, input int e0, input int e1, input int e2);
    i_push     = 1'b1;
    i_push_cnt = PC_W'(cnt);
    i_din      = {I_W'(e2), I_W'(e1), I_W'(e0)};
    step();
    i_push     = 1'b0;
    i_push_cnt = '0;
  endtask

  initial begin
    int base, rise, nlog;
    checks = 0; errors = 0; cyc = 0;
    model_reset();

    // Reset state
    steps(3);
    chk("rst_empty", o_fifo_empty, 1);
    chk("rst_full", o_fifo_full, 0);
    chk("rst_occ", o_occupancy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    i_rstn = 1'b1;
    step();

    // Basic push of 3 and streaming out with latency SHIM_LAT+1
    push_word(3, 'h11, 'h22, 'h33);
    chk("t1_occ_after_push", o_occupancy, 3);
    base = outlog.size();
    i_pop_en = 1'b1;
    rise = cyc;
    steps(8);
    i_pop_en = 1'b0;
    steps(2);
    chk("t1_count", outlog.size() - base, 3);
    chk("t1_d0", logged(base), 'h11);
    chk("t1_d1", logged(base + 1), 'h22);
    chk("t1_d2", logged(base + 2), 'h33);
    chk("t1_latency", (outcyc.size() > base) ? outcyc[base] - rise : -1, SHIM_LAT + 1);
    chk("t1_occ_end", o_occupancy, 0);

    // Bring wptr to 15, drain, then a partial-word push straddling the wrap
    for (int i = 0; i < 4; i++) push_word(3, 'h200 + 3*i, 'h201 + 3*i, 'h202 + 3*i);
    i_pop_en = 1'b1;
    steps(20);
    i_pop_en = 1'b0;
    steps(2);
    base = outlog.size();
    push_word(1, 'hA, 0, 0);
    push_word(2, 'hB, 'hC, 0);
    i_pop_en = 1'b1;
    steps(8);
    i_pop_en = 1'b0;
    steps(2);
    chk("wrap_count", outlog.size() - base, 3);
    chk("wrap_d0", logged(base), 'hA);
    chk("wrap_d1", logged(base + 1), 'hB);
    chk("wrap_d2", logged(base + 2), 'hC);

    // Fill: afull trails occupancy by one cycle, full drops further pushes
    for (int i = 0; i < 4; i++) push_word(3, 'h300 + i, 'h310 + i, 'h320 + i);
    chk("fill_occ12", o_occupancy, 12);
    chk("fill_afull_lag", o_fifo_afull, 0);
    push_word(2, 'h3F0, 'h3F1, 0);
    chk("fill_occ14", o_occupancy, 14);
    chk("fill_afull", o_fifo_afull, 1);
    chk("fill_full", o_fifo_full, 1);
    push_word(1, 'h3FF, 0, 0);
    chk("fill_drop_occ", o_occupancy, 14);

    // Clear concurrent with push and pop
    i_pop_en = 1'b1;
    step();
    i_clearfifo = 1'b1;
    i_push = 1'b1; i_push_cnt = PC_W'(3); i_din = {16'h77, 16'h66, 16'h55};
    step();
    i_clearfifo = 1'b0; i_push = 1'b0; i_push_cnt = '0;
    chk("clr_occ", o_occupancy, 0);
    chk("clr_empty", o_fifo_empty, 1);
    chk("clr_valid", o_valid, 0);
    chk("clr_afull", o_fifo_afull, 0);
    i_pop_en = 1'b0;
    steps(2);

    // Popping an empty FIFO for 4 cycles, then real data again
    nlog = outlog.size();
    i_pop_en = 1'b1;
    steps(4);
    i_pop_en = 1'b0;
    steps(2);
    chk("uf_no_valid", outlog.size() - nlog, 0);
`ifdef FEED_LANE_UNDERFLOW_CNT_EN
    chk("uf_cnt4", o_underflow_cnt, 4);
`endif
    base = outlog.size();
    push_word(1, 'h55, 0, 0);
    i_pop_en = 1'b1;
    steps(6);
    i_pop_en = 1'b0;
    steps(2);
    chk("uf_recover_count", outlog.size() - base, 1);
    chk("uf_recover_data", logged(base), 'h55);

    // Pipeline stall mid-stream
    base = outlog.size();
    for (int i = 0; i < 3; i++) push_word(3, 'h100 + 3*i, 'h101 + 3*i, 'h102 + 3*i);
    i_pop_en = 1'b1;
    steps(3);
    i_pipeline_en = 1'b0;
    nlog = outlog.size();
    steps(3);
    chk("stall_no_output", outlog.size() - nlog, 0);
    i_pipeline_en = 1'b1;
    steps(15);
    i_pop_en = 1'b0;
    steps(2);
    chk("stall_count", outlog.size() - base, 9);
    for (int i = 0; i < 9; i++) chk("stall_order", logged(base + i), 'h100 + i);

    // Randomized traffic, including clears and async resets mid-operation
    for (int n = 0; n < 3000; n++) begin
      i_push        = ($urandom_range(0, 1) == 1);
      i_push_cnt    = i_push ? PC_W'($urandom_range(1, M)) : '0;
      i_din         = {I_W'($urandom), I_W'($urandom), I_W'($urandom)};
      i_pop_en      = ($urandom_range(0, 2) != 0);
      i_pipeline_en = ($urandom_range(0, 7) != 0);
      i_clearfifo   = ($urandom_range(0, 63) == 0);
      i_rstn        = ($urandom_range(0, 499) != 0);
      step();
    end
    i_rstn = 1'b1; i_push = 1'b0; i_clearfifo = 1'b0; i_pop_en = 1'b0;
    steps(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/feed_lane_packed.md
Name: feed_lane_packed

Overview:
- Next-generation X/Y feeder lane buffer: accepts packed multi-element words from the feeder data path and streams one element per systolic-array pipeline step.
- Generalises the fixed-width lane. Adds:
  - partial-word pushes of 1..M elements;
  - an element-granular FIFO with occupancy and almost-full reporting;
  - a parametrised output latency shim (SHIM_LAT) in place of the fixed 2-stage one;
  - an explicit output valid.
- Sits between the feed data manager and one row/column input of the systolic array.

Parameters:
- I_W, 16, element width in bits
- M, 3, max elements per push word
- FIFO_POSITIONS, 16, FIFO depth in elements (>= M, power of 2)
- SHIM_LAT, 2, output pipeline stages between FIFO read and o_data (>= 1)
- AF_THRESH, 12, occupancy at or above which o_fifo_afull asserts (<= FIFO_POSITIONS)
- CNT_W, $clog2(FIFO_POSITIONS+1), occupancy counter width

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_din  in  M*I_W  packed push word; element 0 in LSBs, pushed first
- i_push  in  1  push request
- i_push_cnt  in  $clog2(M+1)  valid elements in i_din (1..M); elements [i_push_cnt..M-1] ignored
- i_clearfifo  in  1  synchronous clear of FIFO, pop register and shim
- i_pipeline_en  in  1  systolic-array pipeline enable
- i_pop_en  in  1  pop request, registered before use
- o_fifo_full  out  1  free space < M
- o_fifo_afull  out  1  registered, occupancy >= AF_THRESH
- o_fifo_empty  out  1  occupancy == 0 (combinational)
- o_occupancy  out  CNT_W  current element count
- o_valid  out  1  o_data carries a real element
- o_data  out  I_W  element stream, 0 when not valid

Behaviour:
- Clock and reset: single clock i_clk; reset i_rstn asynchronous, active-low.
- Reset values:
  - all pointers, occupancy, pop register, shim valid bits and afull = 0;
  - shim data = 0;
  - hence o_fifo_empty=1, o_fifo_full=0, o_valid=0, o_data=0.
- Push:
  - Accepted when i_push && !o_fifo_full.
  - Writes i_push_cnt elements at wptr..wptr+cnt-1 (modulo FIFO_POSITIONS).
  - Advances wptr by i_push_cnt.
  - i_push_cnt == 0 or > M: no write (illegal; assertion in sim).
  - Push while full: dropped, no state change.
- Pop register: pop_en_q <= i_pop_en when i_pipeline_en; held otherwise. fifo_pop = pop_en_q && i_pipeline_en.
- Read, on each fifo_pop:
  - if occupancy > 0: the head element enters shim stage 0 with valid=1 and rptr increments;
  - else a bubble (valid=0, data=0) enters.
- Shim:
  - The shim is a SHIM_LAT-stage shift register.
  - It shifts only on fifo_pop and holds when i_pipeline_en=0.
- Output:
  - o_valid = fifo_pop && last_stage.valid.
  - o_data = o_valid ? last_stage.data : 0.
- Occupancy: next = occ + accepted_push_cnt - (fifo_pop && occ>0). Simultaneous push and pop in one cycle are both honoured. A pop when occ==0 does not count a push arriving the same cycle (no fall-through).
- Flags:
  - full = (FIFO_POSITIONS - occ) < M, from current occupancy.
  - afull is registered one cycle after occupancy; it compensates SRAM read-enable latency.
- Pointer wrap: modulo FIFO_POSITIONS. A partial word straddling the wrap point is written correctly.
- i_clearfifo:
  - Zeros pointers, occupancy, pop_en_q and shim valid/data next cycle; afull=0.
  - Takes priority over same-cycle push and pop, which are discarded.
- Async reset mid-operation discards all contents immediately.

Optional Feature:
- Macro FEED_LANE_UNDERFLOW_CNT_EN.
- With it defined:
  - extra output o_underflow_cnt (16 bits), counting fifo_pop cycles with occupancy==0;
  - saturates at 0xFFFF; cleared by reset and i_clearfifo.
- Without it: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- sauria_cfg_pkg holds:
  - a function clog2-safe width helper;
  - a typedef for the shim stage struct {valid, data};
  - a constant FEED_UNDERFLOW_CNT_W = 16.
- Sub-module fifo_packed_ff covers element storage, multi-element write, single-element read, pointers and occupancy.
- Pop register, shim, flags and the optional counter stay at top level.

Test Plan:
- Reset, then push cnt=3 {0x11,0x22,0x33}; hold i_pop_en=1, i_pipeline_en=1 → o_data 0x11,0x22,0x33 with o_valid=1. First valid output appears SHIM_LAT+1 cycles after pop_en rise; occupancy returns to 0.
- Push partial words cnt=1 (0xA) and cnt=2 (0xB,0xC) with FIFO_POSITIONS=16 and wptr=15 → wrap handled; pop order is A,B,C.
- Fill to occupancy 14 → o_fifo_full=1 (free 2 < 3). A further push is dropped; occupancy stays 14. o_fifo_afull rose one cycle after occupancy reached 12.
- Pop with empty FIFO for 4 cycles → o_valid=0, o_data=0. With the macro, o_underflow_cnt=4; a subsequent push/pop yields valid data.
- Mid-stream i_pipeline_en=0 for 3 cycles → no pops, shim held, o_valid=0. On re-enable the stream resumes with no lost or duplicated element.
- i_clearfifo concurrent with push cnt=3 and pop → next cycle occupancy=0, empty=1, o_valid=0, push discarded.
